rr_arbiter4: RTL and testbench



---
 rtl/rr_arbiter4_if.sv | 25 ++
 rtl/rr_arbiter4.sv | 97 +++++++++
 tb/tb_rr_arbiter4.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The arbiter takes the slave side; requesters (or a bench) take the master side.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a registered grant index and one-hot grant,
// optional hold-time limit, and a mandatory idle cycle between owners.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter4_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic [1:0] winner;
  logic       owner_req;
  logic       hold_expired;

  // First requester at or after the pointer, scanning ptr, ptr+1, ptr+2, ptr+3.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] idx;
    w = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  always_comb begin
    winner       = pick(bus.req, ptr);
    owner_req    = bus.req[bus.gnt_id];
    hold_expired = TIMEOUT_EN && (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= 8'd0;
      bus.gnt     <= 4'b0000;
      bus.gnt_id  <= 2'd0;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            state      <= GRANT;
            bus.gnt_id <= winner;
            bus.gnt    <= 4'b0001 << winner;
            bus.busy   <= 1'b1;
            hold_cnt   <= 8'd0;
          end
        end
        GRANT: begin
          // Release takes priority over the hold limit firing in the same cycle.
          if (!owner_req) begin
            state    <= IDLE;
            bus.gnt  <= 4'b0000;
            bus.busy <= 1'b0;
            ptr      <= bus.gnt_id + 2'd1;
          end else if (hold_expired) begin
            state       <= IDLE;
            bus.gnt     <= 4'b0000;
            bus.busy    <= 1'b0;
            bus.timeout <= 1'b1;
            ptr         <= bus.gnt_id + 2'd1;
          end else begin
            hold_cnt <= sat_inc(hold_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_gnt_consistent: assert property (@(posedge clk) disable iff (rst)
    bus.gnt == (bus.busy ? (4'b0001 << bus.gnt_id) : 4'b0000));

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.gnt));

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: three instances cover MAX_HOLD = 8, 4 and 0.
module tb_rr_arbiter4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter4_if a_if ();
  rr_arbiter4_if t4_if ();
  rr_arbiter4_if t0_if ();

  rr_arbiter4 #(.MAX_HOLD(8)) dut_a  (.clk(clk), .rst(rst), .bus(a_if.slave));
  rr_arbiter4 #(.MAX_HOLD(4)) dut_t4 (.clk(clk), .rst(rst), .bus(t4_if.slave));
  rr_arbiter4 #(.MAX_HOLD(0)) dut_t0 (.clk(clk), .rst(rst), .bus(t0_if.slave));

  int checks = 0;
  int passes = 0;

  logic       st_rst[$];
  logic [3:0] st_req[$];
  logic [7:0] st_exp[$];
  logic [7:0] sb[$];

  // Expected output word: {timeout, busy, gnt_id, gnt}
  function automatic logic [7:0] gr(input logic [1:0] id);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    return {1'b0, 1'b1, id, oh};
  endfunction

  function automatic logic [7:0] idl(input logic [1:0] id, input logic to);
    return {to, 1'b0, id, 4'b0000};
  endfunction

  task automatic add(input logic r, input logic [3:0] q, input logic [7:0] e);
    st_rst.push_back(r);
    st_req.push_back(q);
    st_exp.push_back(e);
  endtask

  task automatic clear_stim();
    st_rst.delete();
    st_req.delete();
    st_exp.delete();
    sb.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs, exp;
    clear_stim();
    add(1'b1, 4'b0000, idl(2'd0, 1'b0));
    add(1'b1, 4'b0000, idl(2'd0, 1'b0));
    add(1'b0, 4'b0100, gr(2'd2));
    add(1'b0, 4'b0000, idl(2'd2, 1'b0));
    for (int i = 0; i < st_req.size(); i++) begin
      rst = st_rst[i];
      a_if.req = st_req[i];
      sb.push_back(st_exp[i]);
      tick();
      obs = {a_if.timeout, a_if.busy, a_if.gnt_id, a_if.gnt};
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL reset[%0d]: got %b expected %b (timeout,busy,gnt_id,gnt)", i, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_rotation();
    logic [7:0] obs, exp;
    logic [1:0] o;
    logic [3:0] oh;
    clear_stim();
    add(1'b1, 4'b0000, idl(2'd0, 1'b0));
    add(1'b0, 4'b1111, gr(2'd0));
    for (int k = 0; k < 5; k++) begin
      o  = 2'(k);
      oh = 4'b0001 << o;
      repeat (3) add(1'b0, 4'b1111, gr(o));
      add(1'b0, 4'b1111 & ~oh, idl(o, 1'b0));
      if (k < 4) add(1'b0, 4'b1111, gr(o + 2'd1));
    end
    add(1'b0, 4'b0000, idl(2'd0, 1'b0));
    for (int i = 0; i < st_req.size(); i++) begin
      rst = st_rst[i];
      a_if.req = st_req[i];
      sb.push_back(st_exp[i]);
      tick();
      obs = {a_if.timeout, a_if.busy, a_if.gnt_id, a_if.gnt};
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL rotation[%0d]: got %b expected %b (timeout,busy,gnt_id,gnt)", i, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_ptr_wrap();
    logic [7:0] obs, exp;
    clear_stim();
    add(1'b0, 4'b1000, gr(2'd3));
    add(1'b0, 4'b1001, gr(2'd3));
    add(1'b0, 4'b0001, idl(2'd3, 1'b0));
    add(1'b0, 4'b1001, gr(2'd0));
    add(1'b0, 4'b0000, idl(2'd0, 1'b0));
    for (int i = 0; i < st_req.size(); i++) begin
      rst = st_rst[i];
      a_if.req = st_req[i];
      sb.push_back(st_exp[i]);
      tick();
      obs = {a_if.timeout, a_if.busy, a_if.gnt_id, a_if.gnt};
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL ptr_wrap[%0d]: got %b expected %b (timeout,busy,gnt_id,gnt)", i, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    logic [7:0] obs, exp;
    clear_stim();
    // Requester 1 holds; requester 2 joins in the second grant cycle.
    add(1'b0, 4'b0010, gr(2'd1));
    add(1'b0, 4'b0010, gr(2'd1));
    add(1'b0, 4'b0110, gr(2'd1));
    add(1'b0, 4'b0110, gr(2'd1));
    add(1'b0, 4'b0110, idl(2'd1, 1'b1));
    add(1'b0, 4'b0110, gr(2'd2));
    // Owner 2 releases exactly when its hold limit is reached.
    repeat (3) add(1'b0, 4'b0100, gr(2'd2));
    add(1'b0, 4'b0000, idl(2'd2, 1'b0));
    // Lone requester is re-granted right after its timeout cycle.
    add(1'b0, 4'b1000, gr(2'd3));
    repeat (3) add(1'b0, 4'b1000, gr(2'd3));
    add(1'b0, 4'b1000, idl(2'd3, 1'b1));
    add(1'b0, 4'b1000, gr(2'd3));
    add(1'b0, 4'b0000, idl(2'd3, 1'b0));
    for (int i = 0; i < st_req.size(); i++) begin
      rst = st_rst[i];
      t4_if.req = st_req[i];
      sb.push_back(st_exp[i]);
      tick();
      obs = {t4_if.timeout, t4_if.busy, t4_if.gnt_id, t4_if.gnt};
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL timeout[%0d]: got %b expected %b (timeout,busy,gnt_id,gnt)", i, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_timeout_disabled();
    logic [7:0] obs, exp;
    clear_stim();
    add(1'b0, 4'b0001, gr(2'd0));
    repeat (300) add(1'b0, 4'b0001, gr(2'd0));
    add(1'b0, 4'b0000, idl(2'd0, 1'b0));
    for (int i = 0; i < st_req.size(); i++) begin
      rst = st_rst[i];
      t0_if.req = st_req[i];
      sb.push_back(st_exp[i]);
      tick();
      obs = {t0_if.timeout, t0_if.busy, t0_if.gnt_id, t0_if.gnt};
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL no_timeout[%0d]: got %b expected %b (timeout,busy,gnt_id,gnt)", i, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [7:0] obs, exp;
    clear_stim();
    add(1'b0, 4'b0100, gr(2'd2));
    add(1'b0, 4'b1111, gr(2'd2));
    add(1'b1, 4'b1111, idl(2'd0, 1'b0));
    add(1'b0, 4'b1111, gr(2'd0));
    add(1'b0, 4'b0000, idl(2'd0, 1'b0));
    for (int i = 0; i < st_req.size(); i++) begin
      rst = st_rst[i];
      a_if.req = st_req[i];
      sb.push_back(st_exp[i]);
      tick();
      obs = {a_if.timeout, a_if.busy, a_if.gnt_id, a_if.gnt};
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL reset_mid_grant[%0d]: got %b expected %b (timeout,busy,gnt_id,gnt)", i, obs, exp);
      else passes++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    a_if.req  = 4'b0000;
    t4_if.req = 4'b0000;
    t0_if.req = 4'b0000;
    test_reset();
    test_rotation();
    test_ptr_wrap();
    test_timeout();
    test_timeout_disabled();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
